// File: rtl/program_sequencer.sv
// program_sequencer: turns debounced front-panel button edges into processor
// runs (core held in reset while the regfile copies a program, then run until
// a branch-to-self halt or a timeout) and into single-word data-memory
// save/load transactions driven from the switches.
module program_sequencer #(
  parameter int COPY_CYCLES = 4,
  parameter int RUN_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fib_act,
  input  logic        sort_act,
  input  logic        save_act,
  input  logic        load_act,
  input  logic [15:0] sw,
  input  logic [31:0] pc,
  input  logic [31:0] mem_rdata,
  output logic        cpu_reset,
  output logic [31:0] program_selector,
  output logic        mem_override,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_oe,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_COPY, S_RUN, S_MEM_WR, S_MEM_RD} state_t;

  localparam int            CW        = (COPY_CYCLES > 1) ? $clog2(COPY_CYCLES) : 1;
  localparam logic [CW-1:0] COPY_LAST = CW'(COPY_CYCLES - 1);
  localparam logic [31:0]   RUN_LAST  = 32'(RUN_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          fib_q, fib_d, sort_q, sort_d, save_q, save_d, load_q, load_d;
  logic [CW-1:0] copy_cnt_q, copy_cnt_d;
  logic [1:0]    prog_id_q, prog_id_d;
  logic [1:0]    sel_q, sel_d;
  logic [31:0]   prev_pc_q, prev_pc_d;
  logic          pv_q, pv_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [31:0]   cycle_count_q, cycle_count_d;
  logic          timeout_q, timeout_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d, wr_q, wr_d, oe_q, oe_d;
  logic          accept, halt;
  logic          unused_sw15;

  assign unused_sw15 = sw[15];

  // Next-state, command acceptance and registered-output computation
  always_comb begin
    state_d       = state_q;
    fib_d         = fib_act;
    sort_d        = sort_act;
    save_d        = save_act;
    load_d        = load_act;
    copy_cnt_d    = copy_cnt_q;
    prog_id_d     = prog_id_q;
    prev_pc_d     = prev_pc_q;
    pv_d          = pv_q;
    addr_d        = addr_q;
    data_d        = data_q;
    load_data_d   = load_data_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    done_d        = 1'b0;
    accept        = 1'b0;
    halt          = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only one edge is taken per cycle; lower-priority edges are dropped.
        if (fib_act & ~fib_q) begin
          state_d = S_COPY; prog_id_d = 2'd1; accept = 1'b1;
        end else if (sort_act & ~sort_q) begin
          state_d = S_COPY; prog_id_d = 2'd2; accept = 1'b1;
        end else if (save_act & ~save_q) begin
          state_d = S_MEM_WR; accept = 1'b1;
        end else if (load_act & ~load_q) begin
          state_d = S_MEM_RD; accept = 1'b1;
        end
        if (accept) begin
          addr_d    = sw[14:8];
          data_d    = sw[7:0];
          timeout_d = 1'b0;
        end
        if (state_d == S_COPY) begin
          copy_cnt_d    = '0;
          cycle_count_d = '0;
          pv_d          = 1'b0;
        end
      end
      S_COPY: begin
        if (copy_cnt_q == COPY_LAST) state_d = S_RUN;
        else copy_cnt_d = copy_cnt_q + 1'b1;
      end
      S_RUN: begin
        cycle_count_d = cycle_count_q + 32'd1;
        prev_pc_d     = pc;
        pv_d          = 1'b1;
        // A branch-to-self halt takes precedence over a same-cycle timeout.
        halt = pv_q & (pc == prev_pc_q);
        if (halt) begin
          state_d = S_IDLE; done_d = 1'b1;
        end else if (cycle_count_q == RUN_LAST) begin
          state_d = S_IDLE; done_d = 1'b1; timeout_d = 1'b1;
        end
      end
      S_MEM_WR: begin
        state_d = S_IDLE; done_d = 1'b1;
      end
      S_MEM_RD: begin
        load_data_d = mem_rdata;
        state_d     = S_IDLE; done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    sel_d  = ((state_d == S_COPY) || (state_d == S_RUN)) ? prog_id_d : 2'd0;
    ovr_d  = (state_d == S_MEM_WR) || (state_d == S_MEM_RD);
    wr_d   = (state_d == S_MEM_WR);
    oe_d   = (state_d == S_MEM_RD);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fib_q         <= 1'b0;
      sort_q        <= 1'b0;
      save_q        <= 1'b0;
      load_q        <= 1'b0;
      copy_cnt_q    <= '0;
      prog_id_q     <= 2'd0;
      sel_q         <= 2'd0;
      prev_pc_q     <= 32'd0;
      pv_q          <= 1'b0;
      addr_q        <= 7'd0;
      data_q        <= 8'd0;
      load_data_q   <= 32'd0;
      cycle_count_q <= 32'd0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      ovr_q         <= 1'b0;
      wr_q          <= 1'b0;
      oe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      fib_q         <= fib_d;
      sort_q        <= sort_d;
      save_q        <= save_d;
      load_q        <= load_d;
      copy_cnt_q    <= copy_cnt_d;
      prog_id_q     <= prog_id_d;
      sel_q         <= sel_d;
      prev_pc_q     <= prev_pc_d;
      pv_q          <= pv_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      load_data_q   <= load_data_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      ovr_q         <= ovr_d;
      wr_q          <= wr_d;
      oe_q          <= oe_d;
    end
  end

  // The core sees reset in the same cycle as the system reset.
  assign cpu_reset        = reset | (state_q == S_COPY);
  assign program_selector = {30'd0, sel_q};
  assign mem_override     = ovr_q;
  assign mem_addr         = {25'd0, addr_q};
  assign mem_wdata        = {24'd0, data_q};
  assign mem_wr           = wr_q;
  assign mem_oe           = oe_q;
  assign load_data        = load_data_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout          = timeout_q;
  assign cycle_count      = cycle_count_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a small core model (PC counts up
// by 4 from a reset vector until it reaches a halt address) and a 128-word
// data memory model.
module tb_program_sequencer;

  localparam int COPY_CYCLES = 4;
  localparam int RUN_TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset, fib_act, sort_act, save_act, load_act;
  logic [15:0] sw;
  logic [31:0] pc, mem_rdata;
  logic        cpu_reset, mem_override, mem_wr, mem_oe, busy, done, timeout;
  logic [31:0] program_selector, mem_addr, mem_wdata, load_data, cycle_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rst_pc, halt_pc;
  logic [31:0] tb_mem [0:127];

  program_sequencer #(.COPY_CYCLES(COPY_CYCLES), .RUN_TIMEOUT(RUN_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .fib_act(fib_act), .sort_act(sort_act),
    .save_act(save_act), .load_act(load_act), .sw(sw), .pc(pc),
    .mem_rdata(mem_rdata), .cpu_reset(cpu_reset),
    .program_selector(program_selector), .mem_override(mem_override),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_oe(mem_oe), .load_data(load_data), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Advance one cycle from one falling edge to the next, updating the core
  // and memory models from what they saw during the elapsed cycle.
  task automatic tick();
    logic        cr, wr;
    logic [6:0]  a;
    logic [31:0] wd;
    cr = cpu_reset; wr = mem_wr; a = mem_addr[6:0]; wd = mem_wdata;
    @(posedge clock);
    @(negedge clock);
    if (wr) tb_mem[a] = wd;
    if (cr) pc = rst_pc;
    else if (pc != halt_pc) pc = pc + 32'd4;
    mem_rdata = tb_mem[mem_addr[6:0]];
  endtask

  // Step until done, tallying core-reset cycles, run cycles, selector
  // deviations and memory strobes; fib/sort are released at release_at.
  task automatic run_until_done(input int maxc, input logic [31:0] sel_exp,
                                input int release_at, output int n_cr,
                                output int n_run, output int n_sel,
                                output int n_mem, output bit got);
    n_cr = 0; n_run = 0; n_sel = 0; n_mem = 0; got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (i == release_at) begin
        fib_act = 1'b0; sort_act = 1'b0;
      end
      if (cpu_reset === 1'b1) n_cr++;
      else if (busy === 1'b1) n_run++;
      if (busy === 1'b1 && program_selector !== sel_exp) n_sel++;
      if (mem_oe !== 1'b0 || mem_wr !== 1'b0) n_mem++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (cpu_reset !== 1'b1) begin
      errors++; $display("FAIL reset_cpu_reset: got %b expected 1", cpu_reset);
    end
    checks++;
    if ({busy, done, timeout, mem_override, mem_wr, mem_oe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, timeout, mem_override, mem_wr, mem_oe});
    end
    checks++;
    if ({program_selector, mem_addr, mem_wdata, load_data, cycle_count} !== 160'd0) begin
      errors++;
      $display("FAIL reset_words: sel %0h addr %0h wdata %0h ld %0h cc %0h expected all 0",
               program_selector, mem_addr, mem_wdata, load_data, cycle_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cpu_reset !== 1'b0) begin
      errors++; $display("FAIL reset_release: cpu_reset got %b expected 0", cpu_reset);
    end
    tick();
  endtask

  task automatic test_fib();
    int n_cr, n_run, n_sel, n_mem;
    bit got;
    rst_pc = 32'h30; halt_pc = 32'h40;
    fib_act = 1'b1;
    tick();
    run_until_done(64, 32'd1, 1, n_cr, n_run, n_sel, n_mem, got);
    checks++;
    if (!got) begin errors++; $display("FAIL fib_done: no done within 64 cycles"); end
    checks++;
    if (n_cr !== COPY_CYCLES) begin
      errors++; $display("FAIL fib_copy_len: got %0d expected %0d", n_cr, COPY_CYCLES);
    end
    checks++;
    if (n_sel !== 0 || n_mem !== 0) begin
      errors++; $display("FAIL fib_sel_mem: sel errs %0d mem strobes %0d expected 0 0", n_sel, n_mem);
    end
    checks++;
    if (n_run !== 6 || cycle_count !== 32'd6) begin
      errors++; $display("FAIL fib_cycles: bench %0d dut %0d expected 6", n_run, cycle_count);
    end
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b0 || program_selector !== 32'd0) begin
      errors++;
      $display("FAIL fib_end: timeout %b busy %b sel %0d expected 0 0 0", timeout, busy, program_selector);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL fib_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_save_load();
    int bad;
    for (int i = 0; i < 8; i++) begin
      sw = {1'b0, 7'(i * 4), 8'(9 - i)};
      save_act = 1'b1;
      tick();
      bad = 0;
      checks++;
      if ({mem_override, mem_wr, mem_oe} !== 3'b110) begin
        errors++; $display("FAIL save_strobe[%0d]: got %b expected 110", i, {mem_override, mem_wr, mem_oe});
      end
      checks++;
      if (mem_addr !== 32'(i * 4) || mem_wdata !== 32'(9 - i)) begin
        errors++;
        $display("FAIL save_word[%0d]: addr %0h data %0h expected %0h %0h", i, mem_addr, mem_wdata, i * 4, 9 - i);
      end
      save_act = 1'b0;
      tick();
      checks++;
      if (done !== 1'b1 || mem_wr !== 1'b0) begin
        errors++; $display("FAIL save_done[%0d]: done %b wr %b expected 1 0", i, done, mem_wr);
      end
      tick();
    end
    sw = {1'b0, 7'd8, 8'hAA};
    load_act = 1'b1;
    tick();
    checks++;
    if ({mem_override, mem_wr, mem_oe} !== 3'b101 || mem_addr !== 32'd8) begin
      errors++;
      $display("FAIL load_strobe: got %b addr %0h expected 101 8", {mem_override, mem_wr, mem_oe}, mem_addr);
    end
    load_act = 1'b0;
    tick();
    checks++;
    if (load_data !== 32'd7 || done !== 1'b1) begin
      errors++; $display("FAIL load_data: got %0h done %b expected 7 1", load_data, done);
    end
    checks++;
    if (cycle_count !== 32'd6 || timeout !== 1'b0) begin
      errors++; $display("FAIL mem_no_cc: cc %0d timeout %b expected 6 0", cycle_count, timeout);
    end
    tick();
  endtask

  task automatic test_priority();
    int n_cr, n_run, n_sel, n_mem, bad;
    bit got;
    rst_pc = 32'h40; halt_pc = 32'h40;
    sw = {1'b0, 7'd8, 8'h00};
    sort_act = 1'b1; load_act = 1'b1;
    tick();
    checks++;
    if (program_selector !== 32'd2 || cpu_reset !== 1'b1 || mem_oe !== 1'b0) begin
      errors++;
      $display("FAIL prio_start: sel %0d cpu_reset %b oe %b expected 2 1 0", program_selector, cpu_reset, mem_oe);
    end
    run_until_done(64, 32'd2, 1, n_cr, n_run, n_sel, n_mem, got);
    checks++;
    if (!got || n_sel !== 0 || n_mem !== 0 || n_cr !== COPY_CYCLES) begin
      errors++;
      $display("FAIL prio_run: done %b sel errs %0d mem %0d copy %0d expected 1 0 0 %0d",
               got, n_sel, n_mem, n_cr, COPY_CYCLES);
    end
    checks++;
    if (cycle_count !== 32'd2 || n_run !== 2) begin
      errors++; $display("FAIL min_run: dut %0d bench %0d expected 2", cycle_count, n_run);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy !== 1'b0 || mem_oe !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL held_load: %0d bad cycles expected 0", bad); end
    checks++;
    if (load_data !== 32'd7) begin
      errors++; $display("FAIL held_load_data: got %0h expected 7", load_data);
    end
    load_act = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n_cr, n_run, n_sel, n_mem;
    bit got;
    rst_pc = 32'h0; halt_pc = 32'hFFFF_FFF0;
    fib_act = 1'b1;
    tick();
    run_until_done(64, 32'd1, 1, n_cr, n_run, n_sel, n_mem, got);
    checks++;
    if (!got || timeout !== 1'b1) begin
      errors++; $display("FAIL to_flag: done %b timeout %b expected 1 1", got, timeout);
    end
    checks++;
    if (n_run !== RUN_TIMEOUT || cycle_count !== 32'(RUN_TIMEOUT)) begin
      errors++; $display("FAIL to_cycles: bench %0d dut %0d expected %0d", n_run, cycle_count, RUN_TIMEOUT);
    end
    tick();
    checks++;
    if (done !== 1'b0 || timeout !== 1'b1) begin
      errors++; $display("FAIL to_sticky: done %b timeout %b expected 0 1", done, timeout);
    end
    rst_pc = 32'h40; halt_pc = 32'h40;
    fib_act = 1'b1;
    tick();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout); end
    run_until_done(64, 32'd1, 1, n_cr, n_run, n_sel, n_mem, got);
    tick();
    // Halt lands on the same RUN cycle as the timeout limit.
    rst_pc = 32'h08; halt_pc = 32'h40;
    fib_act = 1'b1;
    tick();
    run_until_done(64, 32'd1, 1, n_cr, n_run, n_sel, n_mem, got);
    checks++;
    if (!got || timeout !== 1'b0 || cycle_count !== 32'(RUN_TIMEOUT)) begin
      errors++;
      $display("FAIL halt_wins: done %b timeout %b cc %0d expected 1 0 %0d", got, timeout, cycle_count, RUN_TIMEOUT);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    rst_pc = 32'h0; halt_pc = 32'hFFFF_FFF0;
    fib_act = 1'b1;
    tick();
    fib_act = 1'b0;
    for (int i = 0; i < COPY_CYCLES + 2; i++) tick();
    fib_act = 1'b1;
    tick(); tick();
    checks++;
    if (cpu_reset !== 1'b0 || busy !== 1'b1 || program_selector !== 32'd1) begin
      errors++;
      $display("FAIL run_edge_drop: cpu_reset %b busy %b sel %0d expected 0 1 1", cpu_reset, busy, program_selector);
    end
    fib_act = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL mid_reset_comb: got %b expected 1", cpu_reset); end
    tick();
    checks++;
    if (busy !== 1'b0 || program_selector !== 32'd0 || done !== 1'b0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_state: busy %b sel %0d done %b cc %0d expected 0 0 0 0",
               busy, program_selector, done, cycle_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL mid_reset_after: done %b busy %b cpu_reset %b expected 0 0 0", done, busy, cpu_reset);
    end
  endtask

  initial begin
    reset = 1'b1; fib_act = 1'b0; sort_act = 1'b0; save_act = 1'b0; load_act = 1'b0;
    sw = 16'd0; pc = 32'd0; mem_rdata = 32'd0;
    rst_pc = 32'd0; halt_pc = 32'h40;
    for (int i = 0; i < 128; i++) tb_mem[i] = 32'd0;
    @(negedge clock);
    test_reset();
    test_fib();
    test_save_load();
    test_priority();
    test_timeout();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Command sequencer between the debounced front-panel buttons and the processor core. It turns button presses into processor runs: fib and sort are started by holding the core in reset while the register file copies the selected program, then running the core to halt. It also turns presses into single-word data-memory save/load transactions driven from the switches. It owns `cpu_reset`, `program_selector` and the data-memory port override, and reports completion, timeout and run length to the display logic.

## Interface
Parameters:
- `COPY_CYCLES`, default 4: cycles the core is held in reset with `program_selector` valid (≥1).
- `RUN_TIMEOUT`, default 1024: maximum RUN cycles before abort (≥2).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `fib_act`  in  1  debounced level, start fib program.
- `sort_act`  in  1  debounced level, start sort program.
- `save_act`  in  1  debounced level, write switch data to memory.
- `load_act`  in  1  debounced level, read memory to `load_data`.
- `sw`  in  16  switches: `sw[14:8]` address, `sw[7:0]` data; `sw[15]` unused.
- `pc`  in  32  core program counter.
- `mem_rdata`  in  32  data-memory read data (combinational).
- `cpu_reset`  out  1  core reset.
- `program_selector`  out  32  program id to regfile: 0 none, 1 fib, 2 sort.
- `mem_override`  out  1  selects sequencer as data-memory master.
- `mem_addr`  out  32  `{25'd0, addr_q}`.
- `mem_wdata`  out  32  `{24'd0, data_q}`.
- `mem_wr`  out  1  memory write strobe.
- `mem_oe`  out  1  memory output enable.
- `load_data`  out  32  last loaded word.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `timeout`  out  1  sticky; last run aborted.
- `cycle_count`  out  32  RUN cycles of last/current run.

## Operation
- Edge detect: `x_q` registers each `*_act` every cycle, including while busy. A command is pending when `x_act & ~x_q`.
- In IDLE, one pending command is accepted. Priority: fib > sort > save > load. Lower-priority edges in the same cycle are dropped.
- Edges arriving outside IDLE are dropped, not queued.
- On acceptance, `addr_q` ← `sw[14:8]` and `data_q` ← `sw[7:0]`. Also `timeout` ← 0 and `done` ← 0.
- States:
  - IDLE: `cpu_reset`=0, `program_selector`=0, no memory override.
  - COPY (fib/sort): `cpu_reset`=1, `program_selector`=id. `cycle_count` ← 0 on entry. Stays exactly `COPY_CYCLES` cycles, then goes to RUN.
  - RUN: `cpu_reset`=0, `program_selector` held at id. `cycle_count` increments each RUN cycle. `prev_pc` registers `pc`; `pv` is set after the first RUN cycle.
    - Halt: `pv & (pc == prev_pc)`, i.e. a branch-to-self. Goes to IDLE with `done` pulse.
    - Timeout: `cycle_count == RUN_TIMEOUT-1` with no halt. Goes to IDLE with `done` pulse and `timeout`=1.
    - If halt and timeout occur in the same cycle, halt wins and `timeout` stays 0.
  - MEM_WR (save): one cycle. `mem_override`=1, `mem_wr`=1, `mem_oe`=0. Then IDLE with `done`.
  - MEM_RD (load): one cycle. `mem_override`=1, `mem_oe`=1. `load_data` ← `mem_rdata` at the ending edge. Then IDLE with `done`.
- `cycle_count` freezes in IDLE. Memory commands do not alter `cycle_count` or `timeout`.
- `mem_wr`/`mem_oe` are 0 whenever `mem_override`=0.

## Timing
- All outputs are registered, except `cpu_reset` = `reset | (state==COPY)`, so the core is reset in the same cycle as `reset`.
- Reset values: state IDLE, `program_selector` 0, `mem_override`/`mem_wr`/`mem_oe` 0, `mem_addr`/`mem_wdata` 0, `load_data` 0, `busy` 0, `done` 0, `timeout` 0, `cycle_count` 0, all `x_q` 0, `pv` 0.
- Reset asserted mid-COPY, RUN or MEM: the next edge returns to IDLE with reset values. No `done` pulse. An in-flight write is not re-issued.
- Accept edge E → new state visible after E.
  - fib/sort: `cpu_reset` high cycles E+1..E+`COPY_CYCLES`; RUN begins at cycle E+`COPY_CYCLES`+1.
  - save/load: memory strobe in cycle E+1; `done` in cycle E+2; `load_data` valid from E+2.
- Minimum run: halt detected on 2nd RUN cycle gives `cycle_count`=2.
- A button held through a whole run does not retrigger, because `x_q` stays 1.

## Test plan
- Reset, then pulse `fib_act` 2 cycles; core halts at PC 0x40 → `cpu_reset` high exactly 4 cycles, `program_selector`=1 until `done`, `done` one cycle, `timeout`=0, `cycle_count` matches bench count.
- Save loop: for i=0..7, `sw`={1'b0, i*4, 9-i}, pulse `save_act` → eight `mem_wr` pulses, addr i*4, data 9-i. Then load addr 8 → `load_data`=7 at E+2.
- Simultaneous `sort_act`+`load_act` edge → sort run only, `program_selector`=2, no `mem_oe`. `load_act` held high afterwards causes no load.
- Core never halts, `RUN_TIMEOUT`=16 → IDLE after 16 RUN cycles, `timeout`=1, `done` pulse. Next accepted command clears `timeout`.
- `reset` asserted mid-RUN → IDLE next edge, `program_selector`=0, `cpu_reset` high that cycle, no `done`. A `fib_act` edge during RUN is dropped.
